// File: rtl/frac_clk_div.sv
// Fractional clock divider: clk_out periods alternate between N and N+1 clk_in cycles,
// averaging N + F/2^FRAC_W. Define FRAC_CLK_DIV_FRAC_EN to build the fraction accumulator.
module frac_clk_div #(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int DEFAULT_DIV = 326
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              load,
  output logic              load_ack,
  output logic              clk_out,
  output logic              tick
);

  localparam int PW = DIV_W + 1;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] div_act_q;
  logic [DIV_W-1:0] div_shd_q;
  logic             pend_q;
  logic             run_q;
  logic             clk_out_q;
  logic             load_ack_q;
  logic [PW-1:0]    cnt_q;

  logic             carry;
  logic             apply_now;
  logic             boundary;
  logic             take_shd;
  logic [DIV_W-1:0] n_cur;
  logic [PW-1:0]    per_cur;
  logic [PW-1:0]    cnt_inc;

  function automatic logic [PW-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? PW'(2) : {1'b0, d};
  endfunction

  // On the first enabled cycle a pending divisor takes effect in the period starting now.
  // Outputs at cnt = 0 do not depend on P, so only next-state logic sees the shadow value.
  assign apply_now = en & ~run_q & pend_q;
  assign n_cur     = apply_now ? div_shd_q : div_act_q;
  assign per_cur   = clamp_div(n_cur) + PW'(carry);
  assign boundary  = en & (cnt_q == per_cur - PW'(1));
  assign take_shd  = apply_now | (boundary & pend_q);
  assign cnt_inc   = cnt_q + PW'(1);

`ifdef FRAC_CLK_DIV_FRAC_EN
  logic [FRAC_W-1:0] frac_act_q;
  logic [FRAC_W-1:0] frac_shd_q;
  logic [FRAC_W-1:0] acc_q;
  logic              carry_q;
  logic [FRAC_W-1:0] f_next;
  logic [FRAC_W:0]   acc_sum;

  assign f_next  = take_shd ? frac_shd_q : frac_act_q;
  assign acc_sum = {1'b0, acc_q} + {1'b0, f_next};
  assign carry   = carry_q;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      frac_act_q <= '0;
      frac_shd_q <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
    end else begin
      if (load)     frac_shd_q <= div_frac;
      if (take_shd) frac_act_q <= frac_shd_q;
      if (!en) begin
        acc_q   <= '0;
        carry_q <= 1'b0;
      end else if (boundary) begin
        acc_q   <= acc_sum[FRAC_W-1:0];
        carry_q <= acc_sum[FRAC_W];
      end
    end
  end
`else
  // Fraction input has no effect in the integer-only build.
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign carry       = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      div_act_q  <= DEF_DIV;
      div_shd_q  <= DEF_DIV;
      pend_q     <= 1'b0;
      run_q      <= 1'b0;
      clk_out_q  <= 1'b0;
      load_ack_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      run_q      <= en;
      load_ack_q <= boundary & pend_q;

      // A load in the same cycle as a transfer re-arms pending with the newer value.
      if (load) begin
        div_shd_q <= div_int;
        pend_q    <= 1'b1;
      end else if (take_shd) begin
        pend_q    <= 1'b0;
      end
      if (take_shd) div_act_q <= div_shd_q;

      if (!en) begin
        cnt_q     <= '0;
        clk_out_q <= 1'b0;
      end else if (boundary) begin
        cnt_q     <= '0;
        clk_out_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_inc;
        clk_out_q <= (cnt_inc >= (per_cur >> 1));
      end
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = boundary;
  assign load_ack = load_ack_q | apply_now;

endmodule

// File: tb/tb_frac_clk_div.sv
// Self-checking bench for frac_clk_div: per-cycle expectations of clk_out/tick/load_ack
// are queued from period lists and compared on the falling edge of clk_in.
module tb_frac_clk_div;

  localparam int DIV_W       = 8;
  localparam int FRAC_W      = 4;
  localparam int DEFAULT_DIV = 4;
`ifdef FRAC_CLK_DIV_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic              clk_in;
  logic              rst;
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              load;
  logic              load_ack;
  logic              clk_out;
  logic              tick;

  frac_clk_div #(
    .DIV_W      (DIV_W),
    .FRAC_W     (FRAC_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .div_int (div_int),
    .div_frac(div_frac),
    .load    (load),
    .load_ack(load_ack),
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic clk;
    logic tck;
    logic ack;
  } exp_t;

  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string scen     = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", scen, tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input bit c, input bit t, input bit a);
    exp_t e;
    e.clk = c;
    e.tck = t;
    e.ack = a;
    sb_q.push_back(e);
  endtask

  // One clk_out period of length p: floor(p/2) low, then high; tick on the last cycle.
  task automatic push_period(input int p, input bit ack_first);
    for (int i = 0; i < p; i++)
      push_exp(i >= p / 2, i == p - 1, ack_first && (i == 0));
  endtask

  // From a drive point (just after posedge), sample this cycle at negedge, then advance.
  task automatic run_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("clk_out",  32'(clk_out),  32'(e.clk));
        check("tick",     32'(tick),     32'(e.tck));
        check("load_ack", 32'(load_ack), 32'(e.ack));
      end
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic load_cyc(input int d, input int f);
    div_int  = DIV_W'(d);
    div_frac = FRAC_W'(f);
    load     = 1'b1;
    run_cycles(1);
    load     = 1'b0;
  endtask

  // Leaves the bench at the drive point of cycle 0 (cnt = 0) of the first period.
  task automatic do_reset(input string name);
    scen     = name;
    rst      = 1'b0;
    en       = 1'b1;
    load     = 1'b0;
    div_int  = '0;
    div_frac = '0;
    sb_q.delete();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_clk_out",  32'(clk_out),  32'd0);
    check("rst_tick",     32'(tick),     32'd0);
    check("rst_load_ack", 32'(load_ack), 32'd0);
    @(posedge clk_in);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain();
    run_cycles(sb_q.size());
    check("sb_drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, scenario %s", scen);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int p;

    // Default divisor, no fraction: 0,0,1,1 with tick every 4th cycle.
    do_reset("default");
    repeat (3) push_period(4, 1'b0);
    drain();

    // 5 + 8/16: alternating 5/6 periods when the fraction is built, otherwise 5.
    do_reset("frac");
    push_period(4, 1'b0);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + (FRAC_ON ? 8 : 0);
      p   = 5 + ((acc >= 16) ? 1 : 0);
      acc = acc % 16;
      push_period(p, i == 0);
    end
    load_cyc(5, 8);
    drain();

    // Load mid-period: current period finishes at 4, then 3.
    do_reset("mid_load");
    push_period(4, 1'b0);
    push_period(3, 1'b1);
    push_period(3, 1'b0);
    push_period(3, 1'b0);
    run_cycles(1);
    load_cyc(3, 0);
    drain();

    // Divisors 1 and 0 both clamp to 2.
    do_reset("clamp");
    push_period(4, 1'b0);
    push_period(2, 1'b1);
    push_period(2, 1'b0);
    push_period(2, 1'b1);
    push_period(2, 1'b0);
    load_cyc(1, 0);
    run_cycles(5);
    load_cyc(0, 0);
    drain();

    // Two loads in one period: last wins, single acknowledge.
    do_reset("last_wins");
    push_period(4, 1'b0);
    push_period(7, 1'b1);
    push_period(7, 1'b0);
    load_cyc(6, 0);
    load_cyc(7, 0);
    drain();

    // Load on the boundary cycle is deferred to the following boundary.
    do_reset("load_at_wrap");
    push_period(4, 1'b0);
    push_period(4, 1'b0);
    push_period(3, 1'b1);
    push_period(3, 1'b0);
    run_cycles(3);
    load_cyc(3, 0);
    drain();

    // Reset at cnt = 2 aborts the period; a fresh period follows release.
    do_reset("rst_mid");
    push_exp(1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 1'b0, 1'b0);
    run_cycles(2);
    rst = 1'b0;
    @(negedge clk_in);
    check("abort_clk_out",  32'(clk_out),  32'd0);
    check("abort_tick",     32'(tick),     32'd0);
    check("abort_load_ack", 32'(load_ack), 32'd0);
    @(posedge clk_in);
    #1;
    rst = 1'b1;
    push_period(4, 1'b0);
    push_period(4, 1'b0);
    drain();

    // Disable mid-period, load while disabled, re-enable applies it at once.
    do_reset("en_gate");
    push_exp(1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 1'b0, 1'b0);
    run_cycles(2);
    en = 1'b0;
    push_exp(1'b1, 1'b0, 1'b0);
    run_cycles(1);
    push_exp(1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 1'b0, 1'b0);
    load_cyc(5, 0);
    run_cycles(1);
    en = 1'b1;
    push_period(5, 1'b1);
    push_period(5, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/frac_clk_div.md
FRAC_CLK_DIV -- requirements
Module: frac_clk_div

Interface
REQ-001 SHALL have parameter DIV_W, default 16: integer divisor width.
REQ-002 SHALL have parameter FRAC_W, default 4: fractional divisor width.
REQ-003 SHALL have parameter DEFAULT_DIV, default 326: integer divisor active after reset.
REQ-004 Port clk_in  input  1: input clock; all logic is posedge clk_in.
REQ-005 Port rst  input  1: reset, asynchronous, active-low.
REQ-006 Port en  input  1: divider run enable.
REQ-007 Port div_int  input  DIV_W: requested integer divisor.
REQ-008 Port div_frac  input  FRAC_W: requested fraction, in units of 1/2^FRAC_W.
REQ-009 Port load  input  1: one-cycle strobe that captures div_int/div_frac into the shadow register.
REQ-010 Port load_ack  output  1: one-cycle pulse when the shadow value becomes active.
REQ-011 Port clk_out  output  1: divided clock, driven directly from a register.
REQ-012 Port tick  output  1: one-cycle pulse in the last clk_in cycle of each clk_out period.

Function
REQ-013 Period length P = N + c, where N = active integer divisor (values 0 and 1 clamped to 2) and c = carry from the fraction accumulator.
REQ-014 At each period start, acc <= (acc + F) mod 2^FRAC_W; c = carry-out of that add; F = active fraction.
REQ-015 Counter cnt runs 0..P-1 and wraps to 0; the wrap cycle is the period boundary.
REQ-016 clk_out is 0 while cnt < floor(P/2) and 1 otherwise: floor(P/2) cycles low, then ceil(P/2) cycles high.
REQ-017 tick is 1 exactly when cnt == P-1 and en is 1.
REQ-018 Average period is N + F/2^FRAC_W cycles; every individual period is N or N+1 cycles.
REQ-019 load captures into the shadow register and sets pending; a load while pending overwrites the shadow value; the last load wins.
REQ-020 A pending value is transferred to active only at a period boundary; load_ack pulses in the first cycle of the new period; acc is not cleared.
REQ-021 When load coincides with a boundary cycle, the value is captured but applied at the next boundary.
REQ-022 While en is 0: cnt = 0, acc = 0, clk_out = 0, tick = 0; loads are still captured.
REQ-023 On the first cycle with en = 1, a pending value is applied immediately and load_ack pulses once.
REQ-024 No output glitches: clk_out changes only on posedge clk_in, and no combinational path drives clk_out.

Reset
REQ-025 On rst low: cnt = 0, acc = 0, clk_out = 0, tick = 0, load_ack = 0, pending = 0.
REQ-026 On rst low: active and shadow divisor = DEFAULT_DIV, fraction = 0.
REQ-027 Reset asserted mid-period aborts that period immediately; counting restarts from cnt = 0 on the first clk_in edge after release.

Configuration
REQ-028 Macro FRAC_CLK_DIV_FRAC_EN defined: fraction accumulator present, behaviour per REQ-013..REQ-014.
REQ-029 Macro FRAC_CLK_DIV_FRAC_EN undefined: accumulator and fraction shadow not built; div_frac ignored; c = 0; P = N always.

Verification
REQ-030 DEFAULT_DIV = 4, F = 0, en = 1 -> clk_out repeats 0,0,1,1; tick on every 4th cycle.
REQ-031 load with div_int = 5, div_frac = 8 -> period sequence 5,6,5,6...; each 5-period is 2 low/3 high, each 6-period is 3 low/3 high.
REQ-032 load of div_int = 3 at cnt = 1 of a 4-period -> current period completes as 4; load_ack in the next cycle; following periods are 3.
REQ-033 load of div_int = 1, then separately div_int = 0 -> both produce P = 2 (clk_out toggles 0,1).
REQ-034 Two loads (6, then 7) within one period -> a single load_ack; active divisor = 7.
REQ-035 rst low at cnt = 2, or en low mid-period -> clk_out = 0 next cycle; after release, first tick at cnt = P-1 of a fresh period.
